// File: rtl/bt_pwr_seq_ctrl.sv
// Power sequencer for NUM_DOMAINS gated slices plus an independent memory-sleep handshake.
// One domain sequences at a time: retention -> isolation -> switch-off, and the reverse for power-up.

module bt_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module bt_pwr_seq_ctrl #(
  parameter int NUM_DOMAINS = 2,
  parameter int STEP_CYCLES = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_DOMAINS-1:0] pd_req,
  input  logic [NUM_DOMAINS-1:0] PG_ack_signals,
  input  logic                   mem_sleep_req,
  input  logic                   memory_ack,
  input  logic                   err_clr,
  output logic [NUM_DOMAINS-1:0] retention_signals,
  output logic [NUM_DOMAINS-1:0] isolation_signals,
  output logic [NUM_DOMAINS-1:0] shut_down_signals,
  output logic                   memory_sleep,
  output logic [NUM_DOMAINS-1:0] domain_off,
  output logic                   mem_asleep,
  output logic                   busy,
  output logic                   err,
  output logic [2:0]             err_dom
);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, SAVE, ISO, SD, WAIT_OFF, UNSD, WAIT_ON, UNISO, UNRET, ERR
  } state_t;

  state_t                 state;
  logic [NUM_DOMAINS-1:0] ack_s;
  logic                   mack_s;
  logic [IW-1:0]          sel;
  logic [IW-1:0]          pick;
  logic                   pick_vld;
  logic                   dir_down;
  logic [SW-1:0]          step_cnt;
  logic [TW-1:0]          to_cnt;
  logic                   step_done;

  genvar g;
  for (g = 0; g < NUM_DOMAINS; g++) begin : g_ack
    bt_sync2 u_sync (.clk(clk), .reset(reset), .d(PG_ack_signals[g]), .q(ack_s[g]));
  end

  bt_sync2 u_mack (.clk(clk), .reset(reset), .d(memory_ack), .q(mack_s));

  // Descending scan so the lowest mismatching index wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (pd_req[i] != domain_off[i]) begin
        pick     = IW'(i);
        pick_vld = 1'b1;
      end
    end
  end

  assign step_done = (step_cnt == STEP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      sel               <= '0;
      dir_down          <= 1'b0;
      step_cnt          <= '0;
      to_cnt            <= '0;
      retention_signals <= '0;
      isolation_signals <= '0;
      shut_down_signals <= '0;
      domain_off        <= '0;
      busy              <= 1'b0;
      err               <= 1'b0;
      err_dom           <= '0;
    end else begin
      case (state)
        IDLE: begin
          step_cnt <= '0;
          busy     <= pick_vld;
          if (pick_vld) begin
            sel <= pick;
            if (pd_req[pick]) begin
              dir_down                <= 1'b1;
              retention_signals[pick] <= 1'b1;
              state                   <= SAVE;
            end else begin
              dir_down                <= 1'b0;
              shut_down_signals[pick] <= 1'b0;
              state                   <= UNSD;
            end
          end
        end
        SAVE: begin
          step_cnt <= step_done ? '0 : step_cnt + 1'b1;
          if (step_done) begin
            isolation_signals[sel] <= 1'b1;
            state                  <= ISO;
          end
        end
        ISO: begin
          step_cnt <= step_done ? '0 : step_cnt + 1'b1;
          if (step_done) begin
            shut_down_signals[sel] <= 1'b1;
            state                  <= SD;
          end
        end
        SD: begin
          to_cnt <= '0;
          state  <= WAIT_OFF;
        end
        WAIT_OFF: begin
          if (ack_s[sel]) begin
            domain_off[sel] <= 1'b1;
            busy            <= 1'b0;
            state           <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            err     <= 1'b1;
            err_dom <= 3'(sel);
            state   <= ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        UNSD: begin
          to_cnt <= '0;
          state  <= WAIT_ON;
        end
        WAIT_ON: begin
          if (!ack_s[sel]) begin
            step_cnt <= '0;
            state    <= UNISO;
          end else if (to_cnt == TO_LAST) begin
            err     <= 1'b1;
            err_dom <= 3'(sel);
            state   <= ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        UNISO: begin
          step_cnt <= step_done ? '0 : step_cnt + 1'b1;
          if (step_done) begin
            isolation_signals[sel] <= 1'b0;
            state                  <= UNRET;
          end
        end
        UNRET: begin
          step_cnt <= step_done ? '0 : step_cnt + 1'b1;
          if (step_done) begin
            retention_signals[sel] <= 1'b0;
            domain_off[sel]        <= 1'b0;
            busy                   <= 1'b0;
            state                  <= IDLE;
          end
        end
        ERR: begin
          // Controls stay frozen; clearing only records the intended target state.
          if (err_clr) begin
            err             <= 1'b0;
            domain_off[sel] <= dir_down;
            busy            <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memory_sleep <= 1'b0;
      mem_asleep   <= 1'b0;
    end else begin
      memory_sleep <= mem_sleep_req;
      if (memory_sleep && mack_s)
        mem_asleep <= 1'b1;
      else if (!mack_s)
        mem_asleep <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bt_pwr_seq_ctrl.sv
// Bench for bt_pwr_seq_ctrl: cycle table with a scoreboard queue, then multi-cycle corner sequences.

module tb_bt_pwr_seq_ctrl;
  logic       clk;
  logic       reset;
  logic [1:0] pd_req;
  logic [1:0] PG_ack_signals;
  logic       mem_sleep_req;
  logic       memory_ack;
  logic       err_clr;
  logic [1:0] retention_signals;
  logic [1:0] isolation_signals;
  logic [1:0] shut_down_signals;
  logic       memory_sleep;
  logic [1:0] domain_off;
  logic       mem_asleep;
  logic       busy;
  logic       err;
  logic [2:0] err_dom;

  logic [1:0] man_ack;
  logic [1:0] auto_ack;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] ret;
    logic [1:0] iso;
    logic [1:0] sd;
    logic [1:0] doff;
    logic       busy;
    logic       msl;
    logic       masl;
  } out_t;

  typedef struct packed {
    logic [1:0] pd;
    logic [1:0] ack;
    logic       mr;
    logic       ma;
    out_t       exp;
  } vec_t;

  vec_t tbl [19];
  out_t sb [$];

  bt_pwr_seq_ctrl #(.NUM_DOMAINS(2), .STEP_CYCLES(2), .ACK_TIMEOUT(8)) dut (
    .clk(clk),
    .reset(reset),
    .pd_req(pd_req),
    .PG_ack_signals(PG_ack_signals),
    .mem_sleep_req(mem_sleep_req),
    .memory_ack(memory_ack),
    .err_clr(err_clr),
    .retention_signals(retention_signals),
    .isolation_signals(isolation_signals),
    .shut_down_signals(shut_down_signals),
    .memory_sleep(memory_sleep),
    .domain_off(domain_off),
    .mem_asleep(mem_asleep),
    .busy(busy),
    .err(err),
    .err_dom(err_dom)
  );

  // Power-switch model: echoes shut_down when automatic, otherwise follows a manual level.
  assign PG_ack_signals = (auto_ack & shut_down_signals) | (~auto_ack & man_ack);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic out_t cur();
    out_t o;
    o.ret  = retention_signals;
    o.iso  = isolation_signals;
    o.sd   = shut_down_signals;
    o.doff = domain_off;
    o.busy = busy;
    o.msl  = memory_sleep;
    o.masl = mem_asleep;
    return o;
  endfunction

  function automatic vec_t mk(input logic [1:0] pd, input logic [1:0] ack, input logic mr,
                              input logic ma, input logic [1:0] ret, input logic [1:0] iso,
                              input logic [1:0] sd, input logic [1:0] doff, input logic b,
                              input logic msl, input logic masl);
    vec_t v;
    v.pd = pd; v.ack = ack; v.mr = mr; v.ma = ma;
    v.exp.ret = ret; v.exp.iso = iso; v.exp.sd = sd; v.exp.doff = doff;
    v.exp.busy = b; v.exp.msl = msl; v.exp.masl = masl;
    return v;
  endfunction

  function automatic logic [14:0] all_out();
    return {retention_signals, isolation_signals, shut_down_signals, domain_off,
            memory_sleep, mem_asleep, busy, err, err_dom};
  endfunction

  initial begin
    out_t o;
    out_t e;
    int c0, c1, csd, ciso, cret, cdoff;
    logic [1:0] ones;

    clk = 1'b0; reset = 1'b1; pd_req = '0; man_ack = '0; auto_ack = '0;
    mem_sleep_req = 1'b0; memory_ack = 1'b0; err_clr = 1'b0;
    ones = 2'b11;

    // Domain 0 power-down (with concurrent memory handshake), then power-up.
    //            pd     ack    mr    ma    ret    iso    sd     doff   busy  msl   masl
    tbl[0]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    tbl[2]  = mk(2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    tbl[3]  = mk(2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mk(2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1);
    tbl[5]  = mk(2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
    tbl[6]  = mk(2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
    tbl[7]  = mk(2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
    tbl[8]  = mk(2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    tbl[14] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    tbl[15] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    tbl[17] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[18] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    #12;
    chk("reset_outs", 32'(all_out()), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", 32'({domain_off, busy}), 32'd0);

    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      pd_req = tbl[k].pd; man_ack = tbl[k].ack;
      mem_sleep_req = tbl[k].mr; memory_ack = tbl[k].ma;
      sb.push_back(tbl[k].exp);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d", k), 32'(cur()), 32'(e));
    end

    // Both domains requested together: strictly one after the other.
    @(negedge clk); auto_ack = 2'b11; pd_req = 2'b11;
    c0 = -1; c1 = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      o = cur();
      chk("order_inv", 32'((o.sd & ~o.iso) | (o.iso & ~o.ret)), 32'd0);
      chk("no_overlap", 32'($countones(o.ret & ~o.doff) <= 1), 32'd1);
      if (o.doff[0] && c0 < 0) c0 = c;
      if (o.doff[1] && c1 < 0) c1 = c;
      if (o.doff == 2'b11 && !o.busy) break;
    end
    chk("both_off", 32'(domain_off), 32'(ones));
    chk("dom0_first", 32'(c0 >= 0 && c1 > c0), 32'd1);

    // Power-up of domain 1 only.
    @(negedge clk); pd_req = 2'b01;
    csd = -1; ciso = -1; cret = -1; cdoff = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      o = cur();
      chk("order_inv_up", 32'((o.sd & ~o.iso) | (o.iso & ~o.ret)), 32'd0);
      if (!o.sd[1] && csd < 0) csd = c;
      if (!o.iso[1] && ciso < 0) ciso = c;
      if (!o.ret[1] && cret < 0) cret = c;
      if (!o.doff[1] && cdoff < 0) cdoff = c;
      if (!o.doff[1] && !o.busy) break;
    end
    chk("up_sd_first", 32'(csd >= 0 && ciso > csd), 32'd1);
    chk("up_ret_gap", 32'(cret - ciso), 32'd2);
    chk("up_doff_with_ret", 32'(cdoff), 32'(cret));
    e = '{ret: 2'b01, iso: 2'b01, sd: 2'b01, doff: 2'b01, busy: 1'b0, msl: 1'b0, masl: 1'b0};
    chk("up_final", 32'(cur()), 32'(e));

    // Ack timeout on domain 1 power-down.
    @(negedge clk); auto_ack = 2'b01; man_ack = 2'b00; pd_req = 2'b11;
    repeat (13) @(posedge clk);
    #1 chk("no_err_early", 32'(err), 32'd0);
    @(posedge clk); #1;
    chk("err_set", 32'({err, err_dom}), 32'({1'b1, 3'd1}));
    e = '{ret: 2'b11, iso: 2'b11, sd: 2'b11, doff: 2'b01, busy: 1'b1, msl: 1'b0, masl: 1'b0};
    chk("err_outs", 32'(cur()), 32'(e));
    repeat (4) @(posedge clk);
    #1 chk("err_frozen", 32'({err, cur()}), 32'({1'b1, e}));
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1;
    chk("err_clr", 32'({err, domain_off, busy}), 32'({1'b0, 2'b11, 1'b0}));
    @(negedge clk); err_clr = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_clr", 32'(busy), 32'd0);

    // Reset mid-sequence: restart from a clean state, then reset again while in ISO.
    @(negedge clk); auto_ack = 2'b11; pd_req = 2'b01; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    e = '{ret: 2'b01, iso: 2'b00, sd: 2'b00, doff: 2'b00, busy: 1'b1, msl: 1'b0, masl: 1'b0};
    chk("reeval_after_reset", 32'(cur()), 32'(e));
    for (int c = 0; c < 10 && !isolation_signals[0]; c++) begin
      @(posedge clk); #1;
    end
    chk("reached_iso", 32'(isolation_signals), 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset", 32'(all_out()), 32'd0);
    @(negedge clk); reset = 1'b0; pd_req = 2'b00;
    @(posedge clk); #1;
    chk("idle_final", 32'({domain_off, busy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
